// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target endpoint with fixed 7-bit address; optional clock stretching under I2C_TARGET_STRETCH_EN
`timescale 1ns/1ps
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    output logic       scl_oe,
    output logic       addressed,
    output logic       rw,
    output logic [7:0] data_out,
    output logic       out_valid,
    input  logic       ack_write,
    input  logic [7:0] data_in,
    input  logic       tx_valid,
    output logic       tx_load,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_RX,
        S_TX,
        S_LOAD,
        S_IGNORE
    } state_t;

    state_t     state;
    logic [2:0] scl_p;      // [0] first sync stage, [1] synchronized, [2] history
    logic [2:0] sda_p;
    logic [3:0] cnt;        // bit counter; 8 = acknowledge phase armed, 9 = acknowledge clock
    logic [7:0] shreg;
    logic [7:0] txd;
    logic       nack;
    logic       sda_oe;     // 1 = pull SDA low
    logic       tx_ready;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, start_cond, stop_cond;

    assign scl_s      = scl_p[1];
    assign sda_s      = sda_p[1];
    assign scl_rise   =  scl_p[1] & ~scl_p[2];
    assign scl_fall   = ~scl_p[1] &  scl_p[2];
    assign start_cond =  scl_p[1] &  scl_p[2] &  sda_p[2] & ~sda_p[1];
    assign stop_cond  =  scl_p[1] &  scl_p[2] & ~sda_p[2] &  sda_p[1];

    // Open-drain data pin: only ever pull low or float
    assign sda = sda_oe ? 1'b0 : 1'bz;

`ifdef I2C_TARGET_STRETCH_EN
    assign tx_ready = tx_valid;
`else
    logic unused_tx_valid;
    assign unused_tx_valid = tx_valid;
    assign tx_ready        = 1'b1;
`endif

    // Bus synchronizers; idle-high reset value avoids a false START/STOP after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_p <= 3'b111;
            sda_p <= 3'b111;
        end else begin
            scl_p <= {scl_p[1:0], scl};
            sda_p <= {sda_p[1:0], sda};
        end
    end

    // Protocol FSM: bus conditions first, then per-state bit handling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            shreg     <= 8'h00;
            txd       <= 8'h00;
            nack      <= 1'b0;
            sda_oe    <= 1'b0;
            scl_oe    <= 1'b0;
            addressed <= 1'b0;
            rw        <= 1'b0;
            data_out  <= 8'h00;
            out_valid <= 1'b0;
            tx_load   <= 1'b0;
            stop_det  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            tx_load   <= 1'b0;
            stop_det  <= 1'b0;
            if (stop_cond) begin
                state     <= S_IDLE;
                cnt       <= 4'd0;
                sda_oe    <= 1'b0;
                scl_oe    <= 1'b0;
                addressed <= 1'b0;
                busy      <= 1'b0;
                stop_det  <= 1'b1;
            end else if (start_cond) begin
                state     <= S_ADDR;
                cnt       <= 4'd0;
                sda_oe    <= 1'b0;
                scl_oe    <= 1'b0;
                addressed <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            shreg <= {shreg[6:0], sda_s};
                            cnt   <= cnt + 4'd1;
                            if (cnt == 4'd7) begin
                                if (shreg[6:0] == ADDR) begin
                                    state <= S_ADDR_ACK;
                                    rw    <= sda_s;
                                end else begin
                                    state <= S_IGNORE;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (cnt == 4'd8) begin
                                sda_oe    <= 1'b1;
                                addressed <= 1'b1;
                                cnt       <= 4'd9;
                            end else if (!rw) begin
                                state  <= S_RX;
                                sda_oe <= 1'b0;
                                cnt    <= 4'd0;
                            end else if (tx_ready) begin
                                txd     <= data_in;
                                sda_oe  <= ~data_in[7];
                                tx_load <= 1'b1;
                                state   <= S_TX;
                                cnt     <= 4'd0;
                            end else begin
                                sda_oe <= 1'b0;
                                scl_oe <= 1'b1;
                                state  <= S_LOAD;
                            end
                        end
                    end
                    S_RX: begin
                        if (scl_rise && cnt < 4'd8) begin
                            shreg <= {shreg[6:0], sda_s};
                            cnt   <= cnt + 4'd1;
                            if (cnt == 4'd7) begin
                                data_out  <= {shreg[6:0], sda_s};
                                out_valid <= 1'b1;
                            end
                        end else if (scl_fall && cnt == 4'd8) begin
                            sda_oe <= ack_write;
                            cnt    <= 4'd9;
                        end else if (scl_fall && cnt == 4'd9) begin
                            sda_oe <= 1'b0;
                            cnt    <= 4'd0;
                        end
                    end
                    S_TX: begin
                        // Entering from a stretch leaves SCL held one extra clk so bit 7 has setup
                        scl_oe <= 1'b0;
                        if (scl_rise) begin
                            if (cnt == 4'd8) nack <= sda_s;
                            if (cnt != 4'd9) cnt <= cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (cnt < 4'd8) begin
                                sda_oe <= ~txd[6];
                                txd    <= {txd[6:0], 1'b0};
                            end else if (cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                            end else if (nack) begin
                                state     <= S_IGNORE;
                                addressed <= 1'b0;
                                sda_oe    <= 1'b0;
                            end else if (tx_ready) begin
                                txd     <= data_in;
                                sda_oe  <= ~data_in[7];
                                tx_load <= 1'b1;
                                cnt     <= 4'd0;
                            end else begin
                                sda_oe <= 1'b0;
                                scl_oe <= 1'b1;
                                state  <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (tx_ready) begin
                            txd     <= data_in;
                            sda_oe  <= ~data_in[7];
                            tx_load <= 1'b1;
                            state   <= S_TX;
                            cnt     <= 4'd0;
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    logic unused_scl_s;
    assign unused_scl_s = scl_s;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed self-checking bench for i2c_target
`timescale 1ns/1ps
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m;
    logic       sda_low;
    logic       ack_write;
    logic [7:0] data_in;
    logic       tx_valid;
    wire        sda_bus;
    wire        scl_line;
    logic       scl_oe, addressed, rw, out_valid, tx_load, stop_det, busy;
    logic [7:0] data_out;

    int n_chk = 0;
    int n_fail = 0;
    int ov_cnt = 0, tl_cnt = 0, sd_cnt = 0, drv_cnt = 0, oe_cnt = 0, adr_cnt = 0;
    logic [7:0] last_data = 8'h00;

    pullup (sda_bus);
    assign sda_bus  = sda_low ? 1'b0 : 1'bz;
    assign scl_line = scl_m & ~scl_oe;

    always #5 clk = ~clk;

    i2c_target #(.ADDR(7'h50)) dut (
        .clk(clk), .rst_n(rst_n), .scl(scl_line), .sda(sda_bus), .scl_oe(scl_oe),
        .addressed(addressed), .rw(rw), .data_out(data_out), .out_valid(out_valid),
        .ack_write(ack_write), .data_in(data_in), .tx_valid(tx_valid), .tx_load(tx_load),
        .stop_det(stop_det), .busy(busy)
    );

    // Event monitors, sampled away from the active edge
    always @(negedge clk) begin
        if (out_valid) begin ov_cnt = ov_cnt + 1; last_data = data_out; end
        if (tx_load) tl_cnt = tl_cnt + 1;
        if (stop_det) sd_cnt = sd_cnt + 1;
        if (!sda_bus && !sda_low) drv_cnt = drv_cnt + 1;
        if (scl_oe) oe_cnt = oe_cnt + 1;
        if (addressed) adr_cnt = adr_cnt + 1;
    end

    task automatic q;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic scl_up;
        int n = 0;
        scl_m = 1'b1;
        while (!scl_line && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!scl_line) begin
            n_chk++; n_fail++;
            $display("FAIL scl_release: scl still low after %0d clk, required high", n);
        end
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        sda_low = ~b;
        q;
        scl_up;
        q;
        s = sda_bus;
        q;
        scl_m = 1'b0;
        q;
    endtask

    task automatic bus_start;
        sda_low = 1'b0;
        q;
        scl_up;
        q;
        sda_low = 1'b1;
        q;
        scl_m = 1'b0;
        q;
    endtask

    task automatic bus_stop;
        sda_low = 1'b1;
        q;
        scl_up;
        q;
        sda_low = 1'b0;
        q;
        q;
    endtask

    task automatic byte_write(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic byte_read(input logic master_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            b[i] = s;
        end
        bit_xfer(~master_ack, s);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_chk++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want 1", sda_bus); end
        n_chk++; if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL reset_scl_oe: got %b want 0", scl_oe); end
        n_chk++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL reset_addressed: got %b want 0", addressed); end
        n_chk++; if (rw !== 1'b0) begin n_fail++; $display("FAIL reset_rw: got %b want 0", rw); end
        n_chk++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_chk++; if (tx_load !== 1'b0) begin n_fail++; $display("FAIL reset_tx_load: got %b want 0", tx_load); end
        n_chk++; if (stop_det !== 1'b0) begin n_fail++; $display("FAIL reset_stop_det: got %b want 0", stop_det); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_write;
        logic ack;
        int ov0 = ov_cnt, sd0 = sd_cnt;
        ack_write = 1'b1;
        bus_start;
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b want 1", busy); end
        byte_write(8'hA0, ack);
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL write_addr_ack: got %b want 0", ack); end
        n_chk++; if (addressed !== 1'b1) begin n_fail++; $display("FAIL write_addressed: got %b want 1", addressed); end
        n_chk++; if (rw !== 1'b0) begin n_fail++; $display("FAIL write_rw: got %b want 0", rw); end
        byte_write(8'h3C, ack);
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL write_data_ack: got %b want 0", ack); end
        n_chk++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL write_out_valid_count: got %0d want 1", ov_cnt - ov0); end
        n_chk++; if (last_data !== 8'h3C) begin n_fail++; $display("FAIL write_data_out: got %h want 3c", last_data); end
        bus_stop;
        n_chk++; if (sd_cnt - sd0 !== 1) begin n_fail++; $display("FAIL write_stop_det: got %0d want 1", sd_cnt - sd0); end
        n_chk++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL write_addressed_after_stop: got %b want 0", addressed); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
    endtask

    task automatic test_wrong_addr;
        logic ack;
        int ov0 = ov_cnt, drv0 = drv_cnt, adr0 = adr_cnt;
        bus_start;
        byte_write(8'hA2, ack);
        n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL wrong_addr_ack: got %b want 1", ack); end
        byte_write(8'h55, ack);
        bus_stop;
        n_chk++; if (drv_cnt - drv0 !== 0) begin n_fail++; $display("FAIL wrong_addr_sda_driven: got %0d clk want 0", drv_cnt - drv0); end
        n_chk++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL wrong_addr_out_valid: got %0d want 0", ov_cnt - ov0); end
        n_chk++; if (adr_cnt - adr0 !== 0) begin n_fail++; $display("FAIL wrong_addr_addressed: got %0d clk want 0", adr_cnt - adr0); end
    endtask

    task automatic test_read;
        logic ack;
        logic [7:0] b;
        int tl0 = tl_cnt;
        data_in = 8'h96;
        bus_start;
        byte_write(8'hA1, ack);
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL read_addr_ack: got %b want 0", ack); end
        n_chk++; if (rw !== 1'b1) begin n_fail++; $display("FAIL read_rw: got %b want 1", rw); end
        data_in = 8'h5A;
        byte_read(1'b1, b);
        n_chk++; if (b !== 8'h96) begin n_fail++; $display("FAIL read_byte1: got %h want 96", b); end
        data_in = 8'hFF;
        byte_read(1'b0, b);
        n_chk++; if (b !== 8'h5A) begin n_fail++; $display("FAIL read_byte2: got %h want 5a", b); end
        n_chk++; if (tl_cnt - tl0 !== 2) begin n_fail++; $display("FAIL read_tx_load_count: got %0d want 2", tl_cnt - tl0); end
        n_chk++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL read_sda_after_nack: got %b want 1", sda_bus); end
        n_chk++; if (addressed !== 1'b0) begin n_fail++; $display("FAIL read_addressed_after_nack: got %b want 0", addressed); end
        bus_stop;
    endtask

    task automatic test_nack_write;
        logic ack;
        int ov0 = ov_cnt;
        ack_write = 1'b1;
        bus_start;
        byte_write(8'hA0, ack);
        ack_write = 1'b0;
        byte_write(8'h11, ack);
        n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL nack_write_ack: got %b want 1", ack); end
        n_chk++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL nack_write_out_valid: got %0d want 1", ov_cnt - ov0); end
        n_chk++; if (last_data !== 8'h11) begin n_fail++; $display("FAIL nack_write_data: got %h want 11", last_data); end
        bus_stop;
        ack_write = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic ack;
        logic [7:0] b;
        int sd0 = sd_cnt;
        bus_start;
        byte_write(8'hA0, ack);
        byte_write(8'h01, ack);
        n_chk++; if (last_data !== 8'h01) begin n_fail++; $display("FAIL rstart_data: got %h want 01", last_data); end
        data_in = 8'hC3;
        bus_start;
        byte_write(8'hA1, ack);
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rstart_addr_ack: got %b want 0", ack); end
        n_chk++; if (rw !== 1'b1) begin n_fail++; $display("FAIL rstart_rw: got %b want 1", rw); end
        n_chk++; if (sd_cnt - sd0 !== 0) begin n_fail++; $display("FAIL rstart_no_stop: got %0d want 0", sd_cnt - sd0); end
        byte_read(1'b0, b);
        n_chk++; if (b !== 8'hC3) begin n_fail++; $display("FAIL rstart_read: got %h want c3", b); end
        bus_stop;
        n_chk++; if (sd_cnt - sd0 !== 1) begin n_fail++; $display("FAIL rstart_stop: got %0d want 1", sd_cnt - sd0); end
    endtask

    task automatic test_reset_mid_tx;
        logic ack;
        int tl0, sd0;
        data_in = 8'h00;
        bus_start;
        byte_write(8'hA1, ack);
        n_chk++; if (sda_bus !== 1'b0) begin n_fail++; $display("FAIL midtx_sda_driven: got %b want 0", sda_bus); end
        tl0 = tl_cnt;
        sd0 = sd_cnt;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (sda_bus !== 1'b1) begin n_fail++; $display("FAIL midtx_sda_released: got %b want 1", sda_bus); end
        n_chk++; if (addressed !== 1'b0 || busy !== 1'b0 || rw !== 1'b0 || scl_oe !== 1'b0) begin
            n_fail++; $display("FAIL midtx_outputs: got addressed=%b busy=%b rw=%b scl_oe=%b want 0000", addressed, busy, rw, scl_oe);
        end
        n_chk++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL midtx_data_out: got %h want 00", data_out); end
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sda_low = 1'b0;
        scl_up;
        q;
        q;
        n_chk++; if (tl_cnt - tl0 !== 0 || sd_cnt - sd0 !== 0) begin
            n_fail++; $display("FAIL midtx_no_pulses: got tx_load=%0d stop_det=%0d want 0 0", tl_cnt - tl0, sd_cnt - sd0);
        end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midtx_busy_after: got %b want 0", busy); end
    endtask

`ifdef I2C_TARGET_STRETCH_EN
    task automatic test_stretch;
        logic ack;
        logic [7:0] b;
        int bad = 0;
        tx_valid = 1'b0;
        data_in  = 8'h3A;
        bus_start;
        byte_write(8'hA1, ack);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (scl_oe !== 1'b1 || scl_line !== 1'b0) bad++;
        end
        n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL stretch_hold: got %0d released clk want 0", bad); end
        tx_valid = 1'b1;
        byte_read(1'b0, b);
        n_chk++; if (b !== 8'h3A) begin n_fail++; $display("FAIL stretch_read: got %h want 3a", b); end
        bus_stop;
        n_chk++; if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL stretch_release: got %b want 0", scl_oe); end
    endtask
`else
    task automatic test_stretch;
        n_chk++; if (oe_cnt !== 0) begin n_fail++; $display("FAIL no_stretch_scl_oe: got %0d clk want 0", oe_cnt); end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        scl_m     = 1'b1;
        sda_low   = 1'b0;
        ack_write = 1'b1;
        data_in   = 8'h00;
`ifdef I2C_TARGET_STRETCH_EN
        tx_valid  = 1'b1;
`else
        tx_valid  = 1'b0;
`endif
        test_reset;
        test_write;
        test_wrong_addr;
        test_read;
        test_nack_write;
        test_back_to_back;
        test_stretch;
        test_reset_mid_tx;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
